// File: rtl/para_smooth_pkg.sv
// Shared defaults and FSM encoding for the para_smooth boxcar smoother.
package para_smooth_pkg;

    localparam int unsigned ParaDw       = 16;
    localparam int unsigned ParaTapsLog2 = 3;

    typedef enum logic {
        StFill = 1'b0,
        StRun  = 1'b1
    } sm_state_e;

endpackage

// File: rtl/para_smooth_ring.sv
// N x Dw sample ring; presents the oldest entry, which is the slot about to be overwritten.
module para_smooth_ring #(
    parameter int unsigned Dw       = 16,
    parameter int unsigned TapsLog2 = 3
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [Dw-1:0] wdata,
    output logic [Dw-1:0] oldest
);

    localparam int unsigned N = 1 << TapsLog2;

    logic [Dw-1:0]       mem_q [N];
    logic [TapsLog2-1:0] wr_ptr_q;

    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
        end else if (we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Storage has no reset: stale entries are never read until the window refills.
    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign oldest = mem_q[wr_ptr_q];

endmodule

// File: rtl/para_smooth.sv
// Boxcar moving average over 2^TapsLog2 signed samples, with bypass and soft flush.
module para_smooth
    import para_smooth_pkg::*;
#(
    parameter int unsigned Dw       = ParaDw,
    parameter int unsigned TapsLog2 = ParaTapsLog2
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic signed [Dw-1:0] adc_data,
    input  logic                 adc_vld,
    input  logic                 smooth_en,
    input  logic                 clr,
    output logic signed [Dw-1:0] sm_data,
    output logic                 sm_vld,
    output logic                 primed
);

    localparam int unsigned N    = 1 << TapsLog2;
    localparam int unsigned SumW = Dw + TapsLog2;
    localparam int unsigned CntW = TapsLog2 + 1;

    sm_state_e              state_q, state_d;
    logic signed [SumW-1:0] sum_q, sum_d, sub, sum_nxt;
    logic [CntW-1:0]        fill_q, fill_d;
    logic signed [Dw-1:0]   sm_data_q, sm_data_d, oldest;
    logic                   sm_vld_q, sm_vld_d;
    logic                   primed_q, primed_d;
    logic                   accept;

    assign accept = adc_vld && !clr && smooth_en;

    para_smooth_ring #(
        .Dw       (Dw),
        .TapsLog2 (TapsLog2)
    ) u_ring (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (clr || !smooth_en),
        .we      (accept),
        .wdata   (adc_data),
        .oldest  (oldest)
    );

    always_comb begin
        sub = '0;
        if (state_q == StRun) begin
            sub = SumW'(oldest);
        end
        sum_nxt = sum_q + SumW'(adc_data) - sub;
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        fill_d    = fill_q;
        sm_data_d = sm_data_q;
        sm_vld_d  = 1'b0;
        primed_d  = primed_q;
        if (clr) begin
            state_d  = StFill;
            sum_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (!smooth_en) begin
            state_d  = StFill;
            sum_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
            sm_vld_d = adc_vld;
            if (adc_vld) begin
                sm_data_d = adc_data;
            end
        end else if (adc_vld) begin
            sum_d = sum_nxt;
            unique case (state_q)
                StFill: begin
                    fill_d = fill_q + 1'b1;
                    // The Nth accepted sample completes the window and emits the first average.
                    if (fill_q == CntW'(N - 1)) begin
                        state_d   = StRun;
                        sm_vld_d  = 1'b1;
                        primed_d  = 1'b1;
                        sm_data_d = Dw'(sum_nxt >>> TapsLog2);
                    end
                end
                StRun: begin
                    sm_vld_d  = 1'b1;
                    sm_data_d = Dw'(sum_nxt >>> TapsLog2);
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= StFill;
            sum_q     <= '0;
            fill_q    <= '0;
            sm_data_q <= '0;
            sm_vld_q  <= 1'b0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            sm_data_q <= sm_data_d;
            sm_vld_q  <= sm_vld_d;
            primed_q  <= primed_d;
        end
    end

    assign sm_data = sm_data_q;
    assign sm_vld  = sm_vld_q;
    assign primed  = primed_q;

endmodule
